// File: rtl/i2s_codec_if.sv
// I2S master for the audio codec: derives BCLK/LRCK from audio_clk, captures the
// left ADC word into audio_input and serializes audio_output onto both DAC channels.
module i2s_codec_if #(
    parameter int DATA_WIDTH = 16,
    parameter int REQ_LEAD   = 4
) (
    input  logic                  audio_clk,
    input  logic                  reset,
    output logic                  sample_end,
    output logic                  sample_req,
    output logic [DATA_WIDTH-1:0] audio_input,
    input  logic [DATA_WIDTH-1:0] audio_output,
    output logic                  AUD_BCLK,
    output logic                  AUD_ADCLRCK,
    output logic                  AUD_DACLRCK,
    input  logic                  AUD_ADCDAT,
    output logic                  AUD_DACDAT
);

    // Counts are one below the visible value because the pulses are registered.
    localparam logic [7:0] CAPTURE_CNT = 8'(4 * DATA_WIDTH + 2);
    localparam logic [7:0] REQ_CNT     = 8'(255 - REQ_LEAD);
    localparam logic [5:0] LAST_SLOT   = 6'(DATA_WIDTH);

    logic [7:0]            cnt_r;
    logic [7:0]            cnt_next_s;
    logic [DATA_WIDTH-1:0] rx_shift_r;
    logic [DATA_WIDTH-1:0] tx_hold_r;
    logic                  dacdat_r;
    logic                  rx_edge_s;
    logic                  tx_edge_s;
    logic [4:0]            slot_pos_s;
    logic                  dac_bit_s;

    // Bit of the held word that belongs in slot position pos (MSB at pos 1), else 0.
    function automatic logic dac_slot_bit(input logic [DATA_WIDTH-1:0] word,
                                          input logic [4:0]            pos);
        logic [DATA_WIDTH-1:0] shifted;
        if ((pos >= 5'd1) && ({1'b0, pos} <= LAST_SLOT)) begin
            shifted = word >> (LAST_SLOT - {1'b0, pos});
            return shifted[0];
        end else begin
            return 1'b0;
        end
    endfunction

    // Edge qualifiers: rising-BCLK capture in left slots 1..DATA_WIDTH, falling-BCLK launch.
    always_comb begin
        cnt_next_s = cnt_r + 8'd1;
        rx_edge_s  = (cnt_r[1:0] == 2'b01) && (cnt_r[7:2] >= 6'd1) && (cnt_r[7:2] <= LAST_SLOT);
        tx_edge_s  = (cnt_r[1:0] == 2'b11);
        slot_pos_s = cnt_next_s[6:2];
        dac_bit_s  = dac_slot_bit(tx_hold_r, slot_pos_s);
    end

    // Frame counter, ADC deserializer, DAC serializer and handshake pulses.
    always_ff @(posedge audio_clk or posedge reset) begin
        if (reset) begin
            cnt_r       <= 8'd0;
            rx_shift_r  <= '0;
            tx_hold_r   <= '0;
            audio_input <= '0;
            sample_end  <= 1'b0;
            sample_req  <= 1'b0;
            dacdat_r    <= 1'b0;
        end else begin
            cnt_r <= cnt_next_s;
            if (rx_edge_s) begin
                rx_shift_r <= (rx_shift_r << 1) | DATA_WIDTH'(AUD_ADCDAT);
            end
            sample_end <= (cnt_r == CAPTURE_CNT);
            if (cnt_r == CAPTURE_CNT) begin
                audio_input <= rx_shift_r;
            end
            sample_req <= (cnt_r == REQ_CNT);
            // Latch on the wrap so the whole frame, both channels, sees one word.
            if (cnt_r == 8'd255) begin
                tx_hold_r <= audio_output;
            end
            if (tx_edge_s) begin
                dacdat_r <= dac_bit_s;
            end
        end
    end

    assign AUD_BCLK    = cnt_r[1];
    assign AUD_ADCLRCK = cnt_r[7];
    assign AUD_DACLRCK = cnt_r[7];
    assign AUD_DACDAT  = dacdat_r;

endmodule
